// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding and reset constants for the Flappy Bird game controller.
package flappy_pkg;
    typedef enum logic [1:0] {
        ST_LOST   = 2'd0,
        ST_READY  = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_e;

    localparam int RESET_GAP = 100;
endpackage

// File: rtl/flappy_game_ctrl_pipe_lane.sv
// pipe_lane: one scrolling obstacle lane (x down-counter with reload, gap register, bird hit test).
module pipe_lane
    import flappy_pkg::*;
#(
    parameter int X_W       = 10,
    parameter int Y_W       = 11,
    parameter int GAP_W     = 8,
    parameter int PIPE_W    = 50,
    parameter int GAP_H     = 140,
    parameter int BIRD_X    = 264,
    parameter int BIRD_HALF = 20,
    parameter int RELOAD_X  = 639
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             init_i,
    input  logic             advance_i,
    input  logic [X_W-1:0]   init_x_i,
    input  logic [GAP_W-1:0] rand_gap_i,
    input  logic [Y_W-1:0]   bird_y_i,
    output logic [X_W-1:0]   pipe_x_o,
    output logic [GAP_W-1:0] pipe_gap_o,
    output logic             hit_o,
    output logic             wrap_o
);
    logic [X_W-1:0]   x_q;
    logic [GAP_W-1:0] gap_q;
    logic [X_W:0]     px;
    logic [Y_W:0]     by, gp;
    logic             overlap, miss;

    assign wrap_o     = advance_i && x_q == '0;
    assign pipe_x_o   = x_q;
    assign pipe_gap_o = gap_q;

    // Widened operands and addition-only compares keep every bound free of wraparound.
    assign px      = {1'b0, x_q};
    assign by      = {1'b0, bird_y_i};
    assign gp      = (Y_W+1)'(gap_q);
    assign overlap = (X_W+1)'(BIRD_X + BIRD_HALF) > px && (X_W+1)'(BIRD_X - BIRD_HALF) < px + (X_W+1)'(PIPE_W);
    assign miss    = by < gp + (Y_W+1)'(BIRD_HALF) || by + (Y_W+1)'(BIRD_HALF) > gp + (Y_W+1)'(GAP_H);
    assign hit_o   = overlap && miss;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            x_q   <= init_x_i;
            gap_q <= GAP_W'(RESET_GAP);
        end else if (init_i) begin
            x_q   <= init_x_i;
            gap_q <= GAP_W'(RESET_GAP);
        end else if (advance_i) begin
            x_q   <= wrap_o ? X_W'(RELOAD_X) : x_q - X_W'(1);
            gap_q <= wrap_o ? rand_gap_i : gap_q;
        end
    end
endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game FSM, NUM_PIPES scrolling lanes, collision, score/high score and pause.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES    = 2,
    parameter int X_W          = 10,
    parameter int Y_W          = 11,
    parameter int PIPE_SPACING = 320,
    parameter int PIPE_W       = 50,
    parameter int GAP_H        = 140,
    parameter int GAP_W        = 8,
    parameter int BIRD_X       = 264,
    parameter int BIRD_HALF    = 20,
    parameter int SCORE_W      = 4
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic                       step_i,
    input  logic                       jump_i,
    input  logic                       pause_sw_i,
    input  logic                       restart_i,
    input  logic [Y_W-1:0]             bird_y_i,
    input  logic [GAP_W-1:0]           rand_gap_i,
    output logic [1:0]                 state_o,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x_o,
    output logic [NUM_PIPES*GAP_W-1:0] pipe_gap_o,
    output logic [SCORE_W-1:0]         score_o,
    output logic [SCORE_W-1:0]         high_score_o,
    output logic                       hit_o
);
    state_e               state_q;
    logic [SCORE_W-1:0]   score_q, high_q;
    logic                 hit_q, pause_q;
    logic [NUM_PIPES-1:0] lane_hit, lane_wrap;
    logic                 coll, pause_edge, advance, init;

    assign coll       = |lane_hit || bird_y_i == '0;
    assign pause_edge = pause_sw_i && !pause_q;
    assign advance    = state_q == ST_RUN && step_i && !coll && !pause_edge;
    assign init       = state_q == ST_LOST && restart_i;

    genvar i;
    generate
        for (i = 0; i < NUM_PIPES; i++) begin : g_lane
            pipe_lane #(
                .X_W(X_W), .Y_W(Y_W), .GAP_W(GAP_W), .PIPE_W(PIPE_W), .GAP_H(GAP_H),
                .BIRD_X(BIRD_X), .BIRD_HALF(BIRD_HALF), .RELOAD_X(NUM_PIPES*PIPE_SPACING-1)
            ) u_lane (
                .clk_i      (clk_i),
                .clr_i      (clr_i),
                .init_i     (init),
                .advance_i  (advance),
                .init_x_i   (X_W'(BIRD_X + PIPE_SPACING*(i+1))),
                .rand_gap_i (rand_gap_i),
                .bird_y_i   (bird_y_i),
                .pipe_x_o   (pipe_x_o[i*X_W +: X_W]),
                .pipe_gap_o (pipe_gap_o[i*GAP_W +: GAP_W]),
                .hit_o      (lane_hit[i]),
                .wrap_o     (lane_wrap[i])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= ST_READY;
            score_q <= '0;
            high_q  <= '0;
            hit_q   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_sw_i;
            hit_q   <= 1'b0;
            case (state_q)
                ST_READY:  if (jump_i) state_q <= ST_RUN;
                ST_RUN: begin
                    if (coll) begin
                        state_q <= ST_LOST;
                        hit_q   <= 1'b1;
                        high_q  <= score_q > high_q ? score_q : high_q;
                    end else if (pause_edge) begin
                        state_q <= ST_PAUSED;
                    end else if (|lane_wrap && score_q != '1) begin
                        score_q <= score_q + SCORE_W'(1);
                    end
                end
                ST_PAUSED: if (pause_edge) state_q <= ST_RUN;
                ST_LOST: begin
                    if (restart_i) begin
                        state_q <= ST_READY;
                        score_q <= '0;
                    end
                end
            endcase
        end
    end

    assign state_o      = state_q;
    assign score_o      = score_q;
    assign high_score_o = high_q;
    assign hit_o        = hit_q;
endmodule
